// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a small sequencer.
//   Single-cycle codes (logic, ADD/SUB, SLT, unused codes, divide-by-zero)
//   finish one cycle after acceptance. MUL runs a shift-add loop and
//   DIVU/REMU run a restoring divider, one bit per cycle for WIDTH cycles.
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_start                request, sampled only in IDLE
//   i_srca, i_srcb         operands (captured on the accepting edge)
//   i_alucontrol           operation code
//   o_busy, o_done         Moore status: busy in MUL/DIV/DONE, done in DONE
//   o_aluout, o_zero,      registered result, zero flag and signed overflow,
//   o_overflow             updated only when the result becomes valid
//
// state  | meaning
// S_IDLE | waiting for i_start
// S_MUL  | shift-add multiply, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
// S_DONE | result registered, o_done pulses, back to IDLE
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_srca,
  input  logic [WIDTH-1:0] i_srcb,
  input  logic [3:0]       i_alucontrol,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_aluout,
  output logic             o_zero,
  output logic             o_overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LP_ITER = CW'(WIDTH);
  localparam logic [CW-1:0] LP_ONE  = CW'(1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_acc;     // product accumulator / partial remainder
  logic [WIDTH-1:0] r_opa;     // multiplicand (shifts left) / dividend->quotient
  logic [WIDTH-1:0] r_opb;     // multiplier (shifts right) / divisor
  logic [CW-1:0]    r_cnt;
  logic             r_rem_sel;
  logic [WIDTH-1:0] r_aluout;
  logic             r_zero, r_overflow;

  logic [WIDTH-1:0] w_sum, w_diff, w_sc_res;
  logic             w_sc_ovf, w_is_mul, w_is_div, w_last;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_trial, w_sub;
  logic [WIDTH-1:0] w_div_rem, w_div_quo, w_div_res;

  assign w_is_mul = (i_alucontrol == OP_MUL);
  assign w_is_div = ((i_alucontrol == OP_DIVU) || (i_alucontrol == OP_REMU)) && (i_srcb != '0);
  assign w_last   = (r_cnt == LP_ONE);

  // Single-cycle result, evaluated on the live inputs at the accepting edge.
  always_comb begin
    w_sum    = i_srca + i_srcb;
    w_diff   = i_srca - i_srcb;
    w_sc_res = '0;
    w_sc_ovf = 1'b0;
    case (i_alucontrol)
      OP_AND:  w_sc_res = i_srca & i_srcb;
      OP_OR:   w_sc_res = i_srca | i_srcb;
      OP_ADD: begin
        w_sc_res = w_sum;
        w_sc_ovf = (i_srca[WIDTH-1] == i_srcb[WIDTH-1]) && (w_sum[WIDTH-1] != i_srca[WIDTH-1]);
      end
      OP_XOR:  w_sc_res = i_srca ^ i_srcb;
      OP_NOR:  w_sc_res = ~(i_srca | i_srcb);
      OP_SUB: begin
        w_sc_res = w_diff;
        w_sc_ovf = (i_srca[WIDTH-1] != i_srcb[WIDTH-1]) && (w_diff[WIDTH-1] != i_srca[WIDTH-1]);
      end
      OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(i_srca) < $signed(i_srcb))};
      // Only reached here with a zero divisor.
      OP_DIVU: w_sc_res = '1;
      OP_REMU: w_sc_res = i_srca;
      default: w_sc_res = '0;
    endcase
  end

  assign w_mul_acc = r_acc + (r_opb[0] ? r_opa : '0);

  // Restoring step: shift the next dividend bit into the remainder and
  // keep the difference only when it does not borrow.
  always_comb begin
    w_trial = {r_acc, r_opa[WIDTH-1]};
    w_sub   = w_trial - {1'b0, r_opb};
    if (!w_sub[WIDTH]) begin
      w_div_rem = w_sub[WIDTH-1:0];
      w_div_quo = {r_opa[WIDTH-2:0], 1'b1};
    end else begin
      w_div_rem = w_trial[WIDTH-1:0];
      w_div_quo = {r_opa[WIDTH-2:0], 1'b0};
    end
    w_div_res = r_rem_sel ? w_div_rem : w_div_quo;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b1;
    o_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          if (w_is_mul)      w_next = S_MUL;
          else if (w_is_div) w_next = S_DIV;
          else               w_next = S_DONE;
        end
      end
      S_MUL:   if (w_last) w_next = S_DONE;
      S_DIV:   if (w_last) w_next = S_DONE;
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc      <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_cnt      <= '0;
      r_rem_sel  <= 1'b0;
      r_aluout   <= '0;
      r_zero     <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc     <= '0;
            r_opa     <= i_srca;
            r_opb     <= i_srcb;
            r_cnt     <= LP_ITER;
            r_rem_sel <= (i_alucontrol == OP_REMU);
            if (!w_is_mul && !w_is_div) begin
              r_aluout   <= w_sc_res;
              r_zero     <= (w_sc_res == '0);
              r_overflow <= w_sc_ovf;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_acc;
          r_opa <= r_opa << 1;
          r_opb <= r_opb >> 1;
          r_cnt <= r_cnt - LP_ONE;
          if (w_last) begin
            r_aluout   <= w_mul_acc;
            r_zero     <= (w_mul_acc == '0);
            r_overflow <= 1'b0;
          end
        end
        S_DIV: begin
          r_acc <= w_div_rem;
          r_opa <= w_div_quo;
          r_cnt <= r_cnt - LP_ONE;
          if (w_last) begin
            r_aluout   <= w_div_res;
            r_zero     <= (w_div_res == '0);
            r_overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_aluout   = r_aluout;
  assign o_zero     = r_zero;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed bench for alu_mc at WIDTH=32.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] srca, srcb;
  logic [3:0]   alucontrol;
  logic         busy, done, zero, overflow;
  logic [W-1:0] aluout;

  int checks = 0;
  int passes = 0;
  int lat;
  int bad;
  int pulses;

  alu_mc #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_srca(srca), .i_srcb(srcb), .i_alucontrol(alucontrol),
    .o_busy(busy), .o_done(done), .o_aluout(aluout),
    .o_zero(zero), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request, then scramble the inputs after acceptance and
  // count cycles until done (sampled on falling edges).
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int n);
    @(negedge clk);
    start = 1'b1; alucontrol = op; srca = a; srcb = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; srca = 32'hDEADBEEF; srcb = 32'h0BADF00D; alucontrol = 4'b0010;
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic op_check(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] exp_out,
                          input logic exp_zero, input logic exp_ovf);
    int n;
    run_op(op, a, b, n);
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_out"}, 64'(aluout), 64'(exp_out));
    check({tag, "_zero"}, 64'(zero), 64'(exp_zero));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; alucontrol = 4'b0010; srca = 32'd1; srcb = 32'd2;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_aluout", 64'(aluout), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 64'({busy, done}), 64'd0);

    op_check("add_wrap", 4'b0010, 32'h00000001, 32'hFFFFFFFF, 1, 32'h00000000, 1'b1, 1'b0);
    @(negedge clk);
    check("add_done_drop", 64'({busy, done}), 64'd0);
    op_check("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 1, 32'h80000000, 1'b0, 1'b1);
    op_check("sub_ovf", 4'b0110, 32'h80000000, 32'h00000001, 1, 32'h7FFFFFFF, 1'b0, 1'b1);
    op_check("sub_plain", 4'b0110, 32'd10, 32'd3, 1, 32'd7, 1'b0, 1'b0);
    op_check("slt_neg", 4'b0111, 32'hFFFFFFFF, 32'h00000000, 1, 32'd1, 1'b0, 1'b0);
    op_check("slt_pos", 4'b0111, 32'h00000001, 32'h00000000, 1, 32'd0, 1'b1, 1'b0);
    op_check("slt_extreme", 4'b0111, 32'h80000000, 32'h7FFFFFFF, 1, 32'd1, 1'b0, 1'b0);
    op_check("xor", 4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'h0FF00FF0, 1'b0, 1'b0);
    op_check("nor", 4'b0100, 32'hF0F0F0F0, 32'h0F0F0F00, 1, 32'h0000000F, 1'b0, 1'b0);
    op_check("unused", 4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'd0, 1'b1, 1'b0);

    // MUL with busy window and a start pulse while busy.
    @(negedge clk);
    start = 1'b1; alucontrol = 4'b1000; srca = 32'h00012345; srcb = 32'h00001000;
    @(posedge clk);
    bad = 0;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0; srca = 32'hDEADBEEF; srcb = 32'h0BADF00D; alucontrol = 4'b0000;
      end
      if (busy !== 1'b1) bad++;
      if (n < 33 && done !== 1'b0) bad++;
      if (n == 10) begin start = 1'b1; alucontrol = 4'b0010; end
      if (n == 11) start = 1'b0;
    end
    check("mul_busy_window", 64'(bad), 64'd0);
    check("mul_done_33", 64'(done), 64'd1);
    check("mul_out", 64'(aluout), 64'h12345000);
    @(negedge clk);
    check("mul_after", 64'({busy, done}), 64'd0);

    op_check("mul_ones", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000001, 1'b0, 1'b0);
    op_check("mul_zero", 4'b1000, 32'h00000000, 32'h12345678, 33, 32'h00000000, 1'b1, 1'b0);
    op_check("divu", 4'b1001, 32'd100, 32'd7, 33, 32'd14, 1'b0, 1'b0);
    op_check("remu", 4'b1010, 32'd100, 32'd7, 33, 32'd2, 1'b0, 1'b0);
    op_check("divu_big", 4'b1001, 32'hFFFFFFFF, 32'h00000010, 33, 32'h0FFFFFFF, 1'b0, 1'b0);
    op_check("remu_big", 4'b1010, 32'hFFFFFFFF, 32'h00000010, 33, 32'h0000000F, 1'b0, 1'b0);
    op_check("remu_exact", 4'b1010, 32'd42, 32'd6, 33, 32'd0, 1'b1, 1'b0);
    op_check("divu_by0", 4'b1001, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 1'b0, 1'b0);
    op_check("remu_by0", 4'b1010, 32'd5, 32'd0, 1, 32'd5, 1'b0, 1'b0);

    // Reset 10 cycles into a MUL.
    op_check("add_pre", 4'b0010, 32'd2, 32'd3, 1, 32'd5, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; alucontrol = 4'b1000; srca = 32'd7; srcb = 32'd9;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 5) check("mul_hold_out", 64'(aluout), 64'd5);
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_out", 64'(aluout), 64'd0);
    check("abort_zero", 64'(zero), 64'd1);
    reset = 1'b0;
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    check("abort_quiet", 64'(pulses), 64'd0);
    op_check("mul_after_rst", 4'b1000, 32'd3, 32'd5, 33, 32'd15, 1'b0, 1'b0);

    // Back-to-back single-cycle ops with start held high.
    @(negedge clk);
    start = 1'b1; alucontrol = 4'b0000; srca = 32'h12345678; srcb = 32'h87654321;
    @(negedge clk);
    check("b2b_and_done", 64'(done), 64'd1);
    check("b2b_and_out", 64'(aluout), 64'h02244220);
    alucontrol = 4'b0001;
    @(negedge clk);
    check("b2b_gap", 64'({busy, done}), 64'd0);
    @(negedge clk);
    check("b2b_or_done", 64'(done), 64'd1);
    check("b2b_or_out", 64'(aluout), 64'h97755779);
    start = 1'b0;
    @(negedge clk);
    check("b2b_end", 64'({busy, done}), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
